// File: rtl/foobar_pkg.sv
// Shared types and default constants for the foobar pulse-stream monitor.
package foobar_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      CLS_NUM    = 2'b00,
      CLS_FOO    = 2'b01,
      CLS_BAR    = 2'b10,
      CLS_FOOBAR = 2'b11
   } cls_t;

   localparam int FOO_DIV_DEF = 3;
   localparam int BAR_DIV_DEF = 5;
   localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/foobar_monitor_if.sv
// Sample inputs and classification outputs of the foobar monitor.
// master = the side that feeds samples and reads results; slave = the monitor.
interface foobar_monitor_if
   import foobar_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF)
   ();

   logic             en;
   logic             foo;
   logic             bar;
   logic             locked;
   logic             cls_valid;
   cls_t             cls;
   logic             err;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] period_count;

   modport master (
      output en, foo, bar,
      input  locked, cls_valid, cls, err, err_count, period_count
   );

   modport slave (
      input  en, foo, bar,
      output locked, cls_valid, cls, err, err_count, period_count
   );

endinterface

// File: rtl/mod_phase.sv
// Modulo-N phase counter. next_ph is the phase the counter would take on the
// next advance; wrap flags that this advance lands back on phase 0.
module mod_phase #(
   parameter  int N = 3,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         adv,
   output logic [W-1:0] next_ph,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] ph;

   // Successor phase, folding N-1 back to 0.
   always_comb begin
      next_ph = (ph == LAST) ? '0 : ph + 1'b1;
      wrap    = (next_ph == '0);
   end

   // Phase register: clear wins over advance.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clr) ph <= '0;
      else if (adv)   ph <= next_ph;
   end

endmodule

// File: rtl/foobar_monitor.sv
// Receive-side checker: aligns to the generator on a foo+bar sample, then
// predicts each pulse, classifies samples, flags and counts mismatches.
module foobar_monitor
   import foobar_pkg::*;
   #(
   parameter int FOO_DIV = FOO_DIV_DEF,
   parameter int BAR_DIV = BAR_DIV_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   foobar_monitor_if.slave   mon
);

   state_t           state, state_n;
   logic             clr, adv;
   logic [$clog2(FOO_DIV)-1:0] nf;
   logic [$clog2(BAR_DIV)-1:0] nb;
   logic             wrap_f, wrap_b;
   logic             exp_foo, exp_bar;
   logic             cls_valid_n, err_n, err_inc, per_inc;
   cls_t             cls_n;
   logic             cls_valid_q, err_q;
   cls_t             cls_q;
   logic [CNT_W-1:0] err_cnt_q, per_cnt_q;

   mod_phase #(.N(FOO_DIV)) u_ph_foo (
      .clk(clk), .rst(rst), .clr(clr), .adv(adv), .next_ph(nf), .wrap(wrap_f)
   );

   mod_phase #(.N(BAR_DIV)) u_ph_bar (
      .clk(clk), .rst(rst), .clr(clr), .adv(adv), .next_ph(nb), .wrap(wrap_b)
   );

   assign exp_foo = (nf == '0);
   assign exp_bar = (nb == '0);

   // Next state, phase control and next output values for the current sample.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave a value unassigned and infer a latch.
      state_n     = state;
      clr         = 1'b0;
      adv         = 1'b0;
      cls_valid_n = 1'b0;
      cls_n       = CLS_NUM;
      err_n       = 1'b0;
      err_inc     = 1'b0;
      per_inc     = 1'b0;
      if (mon.en) begin
         unique case (state)
            HUNT: begin
               if (mon.foo && mon.bar) begin
                  state_n     = TRACK;
                  clr         = 1'b1;
                  cls_valid_n = 1'b1;
                  cls_n       = CLS_FOOBAR;
               end
            end
            TRACK: begin
               if (mon.foo == exp_foo && mon.bar == exp_bar) begin
                  adv         = 1'b1;
                  cls_valid_n = 1'b1;
                  cls_n       = cls_t'({mon.bar, mon.foo});
                  // Both phases landing on 0 closes a super-period.
                  per_inc     = wrap_f && wrap_b;
               end else begin
                  err_n   = 1'b1;
                  err_inc = 1'b1;
                  clr     = 1'b1;
                  if (mon.foo && mon.bar) begin
                     // A foo+bar sample is itself a valid alignment point.
                     cls_valid_n = 1'b1;
                     cls_n       = CLS_FOOBAR;
                  end else begin
                     state_n = HUNT;
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   // State, registered outputs and statistic counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         cls_valid_q <= 1'b0;
         cls_q       <= CLS_NUM;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         per_cnt_q   <= '0;
      end else begin
         state       <= state_n;
         cls_valid_q <= cls_valid_n;
         cls_q       <= cls_n;
         err_q       <= err_n;
         if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
         if (per_inc)                    per_cnt_q <= per_cnt_q + 1'b1;
      end
   end

   assign mon.locked       = (state == TRACK);
   assign mon.cls_valid    = cls_valid_q;
   assign mon.cls          = cls_q;
   assign mon.err          = err_q;
   assign mon.err_count    = err_cnt_q;
   assign mon.period_count = per_cnt_q;

endmodule

// File: tb/tb_foobar_monitor.sv
// Directed bench for foobar_monitor with FOO_DIV=3, BAR_DIV=5, CNT_W=8.
module tb_foobar_monitor;
   import foobar_pkg::*;

   typedef struct {
      logic       foo;
      logic       bar;
      logic       exp_locked;
      logic       exp_valid;
      logic [1:0] exp_cls;
      logic       exp_err;
      logic [7:0] exp_ecnt;
      logic [7:0] exp_per;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_pass  = 0;

   vec_t clean_tab [16];
   vec_t drop_tab  [16];

   foobar_monitor_if #(.CNT_W(8)) bus ();

   foobar_monitor #(.FOO_DIV(3), .BAR_DIV(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .mon(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Drive one cycle of inputs, let one edge pass, return 1 time unit later.
   task automatic step(input logic en, input logic foo, input logic bar);
      bus.en  = en;
      bus.foo = foo;
      bus.bar = bar;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      bus.en = 1'b0;
   endtask

   function automatic logic gf(int c);
      return (c % 3) == 0;
   endfunction

   function automatic logic gb(int c);
      return (c % 5) == 0;
   endfunction

   // Apply one enabled sample, check, then gap en-low cycles with junk inputs.
   task automatic apply(input vec_t v, input int gap, input string tag);
      step(1'b1, v.foo, v.bar);
      check({tag, " locked"}, bus.locked, v.exp_locked);
      check({tag, " cls_valid"}, bus.cls_valid, v.exp_valid);
      if (v.exp_valid) check({tag, " cls"}, bus.cls, v.exp_cls);
      check({tag, " err"}, bus.err, v.exp_err);
      check({tag, " err_count"}, bus.err_count, v.exp_ecnt);
      check({tag, " period_count"}, bus.period_count, v.exp_per);
      for (int g = 0; g < gap; g++) begin
         step(1'b0, 1'b1, 1'b1);
         check({tag, " idle cls_valid"}, bus.cls_valid, 1'b0);
         check({tag, " idle err"}, bus.err, 1'b0);
         check({tag, " idle locked"}, bus.locked, v.exp_locked);
         check({tag, " idle period_count"}, bus.period_count, v.exp_per);
      end
   endtask

   initial begin
      //             foo  bar  lock val  cls    err  ecnt per
      clean_tab = '{
         '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 8'd0, 8'd0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 8'd0, 8'd1}
      };
      // Foo dropped at count 3; hunting until the foo+bar at count 15.
      drop_tab = '{
         '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 8'd1, 8'd0}
      };

      bus.en = 1'b0; bus.foo = 1'b0; bus.bar = 1'b0;

      // Reset state, with en and foo+bar high to show reset wins.
      do_reset();
      check("reset locked", bus.locked, 1'b0);
      check("reset cls_valid", bus.cls_valid, 1'b0);
      check("reset cls", bus.cls, 2'b00);
      check("reset err", bus.err, 1'b0);
      check("reset err_count", bus.err_count, 8'd0);
      check("reset period_count", bus.period_count, 8'd0);

      // Clean lock.
      for (int i = 0; i < 16; i++) apply(clean_tab[i], 0, $sformatf("clean[%0d]", i));

      // Gapped enable: same stream, 3 en-low cycles after every sample.
      do_reset();
      for (int i = 0; i < 16; i++) apply(clean_tab[i], 3, $sformatf("gap[%0d]", i));

      // Dropped foo.
      do_reset();
      for (int i = 0; i < 16; i++) apply(drop_tab[i], 0, $sformatf("drop[%0d]", i));

      // Realigning mismatch at count 7.
      do_reset();
      for (int c = 0; c < 7; c++) step(1'b1, gf(c), gb(c));
      check("realign pre locked", bus.locked, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("realign err", bus.err, 1'b1);
      check("realign cls_valid", bus.cls_valid, 1'b1);
      check("realign cls", bus.cls, 2'b11);
      check("realign locked", bus.locked, 1'b1);
      check("realign err_count", bus.err_count, 8'd1);
      check("realign period_count", bus.period_count, 8'd0);
      for (int c = 1; c < 16; c++) begin
         step(1'b1, gf(c), gb(c));
         check($sformatf("retrack[%0d] err", c), bus.err, 1'b0);
         check($sformatf("retrack[%0d] cls_valid", c), bus.cls_valid, 1'b1);
         if (c == 3) check("retrack[3] cls", bus.cls, 2'b01);
         if (c == 5) check("retrack[5] cls", bus.cls, 2'b10);
         if (c == 14) check("retrack[14] period_count", bus.period_count, 8'd0);
      end
      check("retrack period_count", bus.period_count, 8'd1);
      check("retrack err_count", bus.err_count, 8'd1);

      // Saturation: align, then 300 foo+bar samples each mismatch and realign.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1, 1'b1);
         if (i == 0)   check("sat err_count first", bus.err_count, 8'd1);
         if (i == 253) check("sat err_count 254", bus.err_count, 8'd254);
         if (i == 254) check("sat err_count 255", bus.err_count, 8'd255);
         if (i == 255) check("sat err_count hold", bus.err_count, 8'd255);
      end
      check("sat err_count final", bus.err_count, 8'd255);
      check("sat err pulse", bus.err, 1'b1);
      check("sat locked", bus.locked, 1'b1);

      // Wrap: 257 clean super-periods after alignment.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      for (int p = 0; p < 257; p++) begin
         for (int c = 1; c < 16; c++) step(1'b1, gf(c), gb(c));
         if (p == 0)   check("wrap period 1", bus.period_count, 8'd1);
         if (p == 254) check("wrap period 255", bus.period_count, 8'd255);
         if (p == 255) check("wrap period 256", bus.period_count, 8'd0);
      end
      check("wrap period 257", bus.period_count, 8'd1);
      check("wrap err_count", bus.err_count, 8'd0);

      // Reset mid-TRACK at phase 4; the reset-cycle sample would mismatch.
      for (int c = 1; c < 5; c++) step(1'b1, gf(c), gb(c));
      check("midrst pre locked", bus.locked, 1'b1);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      check("midrst locked", bus.locked, 1'b0);
      check("midrst cls_valid", bus.cls_valid, 1'b0);
      check("midrst cls", bus.cls, 2'b00);
      check("midrst err", bus.err, 1'b0);
      check("midrst err_count", bus.err_count, 8'd0);
      check("midrst period_count", bus.period_count, 8'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check($sformatf("midrst foo-only[%0d] locked", i), bus.locked, 1'b0);
         check($sformatf("midrst foo-only[%0d] cls_valid", i), bus.cls_valid, 1'b0);
         check($sformatf("midrst foo-only[%0d] err", i), bus.err, 1'b0);
      end
      step(1'b1, 1'b1, 1'b1);
      check("midrst relock locked", bus.locked, 1'b1);
      check("midrst relock cls_valid", bus.cls_valid, 1'b1);
      check("midrst relock cls", bus.cls, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
